// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: turns debounced key pulses into a queued movement direction applied once per step.
// Optional macro TURN_QUEUE_EN selects a 2-deep turn FIFO; otherwise a single last-wins pending slot.
module snake_dir_ctrl #(
  parameter logic [23:0] STEP_CNT = 24'd12499999,
  parameter logic [1:0]  INIT_DIR = 2'd1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       run,
  input  logic       key_up,
  input  logic       key_right,
  input  logic       key_down,
  input  logic       key_left,
  output logic [1:0] dir,
  output logic       step,
  output logic       key_drop,
  output logic [1:0] q_cnt
);

  localparam int unsigned CNT_W = 24;
  localparam int unsigned DIR_W = 2;
  localparam int unsigned KEY_W = 4;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic [DIR_W-1:0] q0_q, q0_d;
  logic [1:0]       qcnt_q, qcnt_d;
  logic             step_q, step_d;
  logic             drop_q, drop_d;

  logic             step_hit;
  logic             pop;
  logic [KEY_W-1:0] key_vec;
  logic             key_any;
  logic             key_multi;
  logic [DIR_W-1:0] key_sel;
  logic [DIR_W-1:0] ref_dir;
  logic             legal;

`ifdef TURN_QUEUE_EN
  logic [DIR_W-1:0] q1_q, q1_d;
  logic [1:0]       occ_pop;
  logic [DIR_W-1:0] head_pop;
  logic             push;
`endif

  // Step timing, pop, key select and queue update.
  always_comb begin
    step_hit  = run && (cnt_q == STEP_CNT);
    cnt_d     = '0;
    step_d    = step_hit;
    if (run && !step_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    pop   = step_hit && (qcnt_q != 2'd0);
    dir_d = pop ? q0_q : dir_q;

    key_vec   = {key_up, key_right, key_down, key_left};
    key_any   = |key_vec;
    key_multi = (key_vec & KEY_W'(key_vec - KEY_W'(1))) != '0;
    if (key_up)         key_sel = 2'd0;
    else if (key_right) key_sel = 2'd1;
    else if (key_down)  key_sel = 2'd2;
    else                key_sel = 2'd3;

`ifdef TURN_QUEUE_EN
    occ_pop  = qcnt_q - 2'(pop);
    head_pop = pop ? q1_q : q0_q;
    // Validate against the youngest entry surviving the pop, else the post-pop direction.
    if (occ_pop == 2'd2)      ref_dir = q1_q;
    else if (occ_pop == 2'd1) ref_dir = head_pop;
    else                      ref_dir = dir_d;
    legal  = (key_sel != ref_dir) && (key_sel != (ref_dir ^ 2'd2));
    push   = key_any && legal && (occ_pop != 2'd2);
    q0_d   = head_pop;
    q1_d   = q1_q;
    if (push) begin
      if (occ_pop == 2'd0) q0_d = key_sel;
      else                 q1_d = key_sel;
    end
    qcnt_d = occ_pop + 2'(push);
    drop_d = key_multi || (key_any && !push);
`else
    ref_dir = dir_d;
    legal   = (key_sel != ref_dir) && (key_sel != (ref_dir ^ 2'd2));
    q0_d    = q0_q;
    qcnt_d  = pop ? 2'd0 : qcnt_q;
    if (key_any && legal) begin
      q0_d   = key_sel;
      qcnt_d = 2'd1;
    end
    drop_d = key_multi || (key_any && !legal);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q  <= '0;
      dir_q  <= INIT_DIR;
      q0_q   <= '0;
      qcnt_q <= '0;
      step_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      q0_q   <= q0_d;
      qcnt_q <= qcnt_d;
      step_q <= step_d;
      drop_q <= drop_d;
    end
  end

`ifdef TURN_QUEUE_EN
  always_ff @(posedge clk) begin
    if (!rstn) q1_q <= '0;
    else       q1_q <= q1_d;
  end
`endif

  assign dir      = dir_q;
  assign step     = step_q;
  assign key_drop = drop_q;
  assign q_cnt    = qcnt_q;

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Consumer end of the key debouncer interface: takes four single-cycle debounced key pulses (up/right/down/left) and turns them into the snake's movement direction.
- Generates the game step strobe internally and applies one queued turn per step.
- Rejects reversals and redundant turns.
- Sits between the four key debouncers and the snake body/position engine.

Parameters:
- STEP_CNT, 24'd12499999: step period minus one, in clk cycles (0.25 s at 50 MHz).
- INIT_DIR, 2'd1: direction after reset. Encoding: 0 up, 1 right, 2 down, 3 left.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; synchronous, active-low
- run  in  1  level; 1 = game running, step counter advances
- key_up  in  1  debounced one-cycle pulse
- key_right  in  1  debounced one-cycle pulse
- key_down  in  1  debounced one-cycle pulse
- key_left  in  1  debounced one-cycle pulse
- dir  out  2  current movement direction (registered)
- step  out  1  one-cycle pulse; snake advances one cell in direction dir
- key_drop  out  1  one-cycle pulse, registered; a key pulse was discarded
- q_cnt  out  2  number of pending turns (0..2)

Behaviour:
- Reset (rstn low at a clk edge):
  - dir=INIT_DIR, step=0, key_drop=0, q_cnt=0.
  - Step counter cnt=0; queue entries cleared.
  - Reset mid-operation flushes all pending turns.
- Step counter, 24-bit cnt:
  - run=1, cnt<STEP_CNT: cnt<=cnt+1, step<=0.
  - run=1, cnt==STEP_CNT: cnt<=0, step<=1, pop occurs on this same edge.
  - run=0: cnt<=0, step<=0, no pop. Keys are still accepted into the queue.
  - step period is STEP_CNT+1 cycles. dir already holds the new value in the cycle step is high.
- Key select:
  - At most one key is taken per cycle. Priority: up > right > down > left.
  - Lower-priority pulses in the same cycle are discarded; key_drop<=1.
- Queue: FIFO, depth 2, entries 2 bits each.
  - Pop: on a step edge with q_cnt>0, dir<=head and the tail shifts to head. If q_cnt==0, dir holds.
  - Reference direction ref: if any entry remains after this edge's pop, ref is the youngest remaining entry; otherwise ref is the value dir holds after this edge.
  - Accept: selected key k with k!=ref and k!=(ref^2) is pushed at the tail.
  - Reject: k==ref (redundant) or k==ref^2 (reversal). Not pushed; key_drop<=1.
  - Full: q_cnt==2 after this edge's pop means the key is not pushed; key_drop<=1.
  - Simultaneous pop and push on one edge: the pop is applied first. Net q_cnt is unchanged when both occur.
- key_drop is high exactly one cycle after the offending key cycle, otherwise 0.
- q_cnt always equals the registered queue occupancy.

Optional Feature:
- Macro TURN_QUEUE_EN.
- Defined: queue behaves as described above, depth 2.
- Undefined: single pending slot, q_cnt max 1.
  - A valid key overwrites a pending entry (last wins), validated against dir after this edge, not against the pending entry.
  - Full never causes a drop. Reversal, redundant and priority-loser drops still pulse key_drop.

Test Plan (STEP_CNT=3, TURN_QUEUE_EN defined unless stated):
1. rstn low 1 cycle with a queue pending and run=1 -> next cycle dir=1, q_cnt=0, step=0, key_drop=0. First step appears 4 cycles after rstn release.
2. run=1, key_right pulse, then key_left pulse -> both rejected, key_drop pulses twice, q_cnt=0, dir stays 1 across steps.
3. dir=1, key_up then key_left before the next step -> step#1 dir=0, step#2 dir=3, q_cnt goes 2,1,0.
4. dir=1, key_up, key_left, key_down in consecutive cycles -> third key: key_drop=1, q_cnt=2, dirs 0 then 3.
5. key_up and key_down high in the same cycle -> up queued, key_drop=1. key_down pulse on the same edge as a step that pops up (dir becomes 0) -> rejected as reversal.
6. TURN_QUEUE_EN undefined, dir=1, key_up then key_down before the step -> slot holds 2, q_cnt=1, no key_drop; after the step, dir=2.
